output_port_serializer: RTL and testbench
=========================================

// Module: output_port_serializer
// PURPOSE
//  Downstream consumer of the processor's output register (RegOut).
//  Watches the parallel output value and, whenever it changes, transmits the new value
//  off-chip as one UART-style serial frame on TxD.
//  Buffers one pending value while a frame is in flight, so fast output updates are not silently lost.
//  Flags an overrun when an update has to be discarded.
// PARAMETERS
//  Psize        8   data width; must match the output register width
//  CLKS_PER_BIT 16  clk cycles per serial bit; must be >= 2
// PORTS
//  clk          in   1      system clock; all logic on its rising edge
//  Reset        in   1      synchronous, active-high reset
//  PortIn       in   Psize  parallel value taken from RegOut
//  Enable       in   1      1 = change detection armed; 0 = input changes ignored
//  ClearOverrun in   1      1-cycle pulse; clears Overrun
//  TxD          out  1      serial line; idles high
//  Busy         out  1      1 while a frame is being sent (state != IDLE)
//  Overrun      out  1      sticky; set when a pending value is overwritten
// BEHAVIOUR
//  Reset (Reset=1 at a clk edge):
//   - TxD=1, Busy=0, Overrun=0.
//   - state=IDLE; bit and baud counters=0; pending slot empty.
//   - LastSeen=0, matching RegOut's reset value, so no frame is sent after reset.
//   - Reset asserted mid-frame aborts the frame immediately; TxD=1 on the next cycle.
//  Change detection, evaluated every edge:
//   - chg = Enable & (PortIn != LastSeen).
//   - LastSeen <= PortIn every cycle, regardless of Enable.
//   - While Enable=0, changes are therefore absorbed and never transmitted.
//  FSM states: IDLE, START, DATA, STOP.
//   - IDLE: on chg, Shift<=PortIn and go to START. TxD goes low on the cycle after the edge where the change is seen.
//   - START: TxD=0 for CLKS_PER_BIT cycles, then go to DATA.
//   - DATA: TxD=Shift[0], LSB first; each bit is held CLKS_PER_BIT cycles, then Shift>>=1.
//     After Psize bits, go to STOP.
//   - STOP: TxD=1 for CLKS_PER_BIT cycles.
//     At the end of STOP: if the pending slot is full, load it into Shift, empty the slot and go to START (no idle gap).
//     Otherwise go to IDLE.
//   - Frame length = (Psize+2)*CLKS_PER_BIT cycles.
//   - Busy=0 only in IDLE.
//  Pending slot (1 deep):
//   - A chg while state != IDLE writes PortIn into the slot.
//   - If the slot is already full, the old value is overwritten (newest wins) and Overrun<=1.
//  Simultaneous events:
//   - chg on the final STOP cycle with the slot empty: PortIn goes straight to Shift and the next frame starts.
//     This is treated as IDLE.
//   - chg on the final STOP cycle with the slot full: the slot moves to Shift and PortIn enters the slot.
//     No overrun.
//   - ClearOverrun on the same cycle as a new overrun: set wins, Overrun stays 1.
//  Enable dropping mid-frame: the current frame and any pending frame still complete.
//  Counters:
//   - Baud counter counts 0..CLKS_PER_BIT-1 and wraps.
//   - Bit counter counts 0..Psize-1; it is only advanced in DATA.
// TESTING
//  1 Reset with PortIn=0, Enable=1, hold 50 cycles -> TxD=1, Busy=0, Overrun=0 throughout.
//  2 CLKS_PER_BIT=4, PortIn 00->A5 -> TxD = 0|1,0,1,0,0,1,0,1|1, 4 cycles per bit.
//    Busy=1 for exactly 40 cycles, then 0.
//  3 Mid-frame, PortIn->3C -> the 3C frame starts the cycle after the A5 stop bit ends.
//    Busy stays 1 for 80 cycles; Overrun=0.
//  4 During a frame, PortIn goes 11->22->33 -> the frames sent are 11 then 33; Overrun=1.
//    A ClearOverrun pulse then returns Overrun to 0.
//  5 Enable=0, PortIn toggles 55/AA, then Enable=1 with no further change -> no frame; TxD=1.
//  6 Reset pulsed during DATA bit 3 -> TxD=1 on the next cycle, Busy=0, pending discarded.
//    With PortIn unchanged after release, no frame is sent.

Source files
------------

// File: rtl/output_port_serializer.sv
// output_port_serializer
// Watches the parallel output register value and sends every change off-chip
// as one UART-style frame (start bit, Psize data bits LSB first, stop bit) on TxD.
// A one-deep pending slot holds an update that arrives while a frame is in
// flight; a second update before that slot drains overwrites it and raises the
// sticky Overrun flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for a change on PortIn
// START | start bit (TxD=0) for CLKS_PER_BIT cycles
// DATA  | Psize data bits from shift_q[0], one every CLKS_PER_BIT cycles
// STOP  | stop bit (TxD=1); at its end chain the pending value or go idle
module output_port_serializer #(
  parameter int Psize        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [Psize-1:0] PortIn,
  input  logic             Enable,
  input  logic             ClearOverrun,
  output logic             TxD,
  output logic             Busy,
  output logic             Overrun
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (Psize > 1) ? $clog2(Psize) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(Psize - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [Psize-1:0] shift_q, shift_d;
  logic [Psize-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [Psize-1:0] last_q, last_d;
  logic             overrun_q, overrun_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;

  logic             chg;
  logic             baud_end;
  logic             stash;
  logic             set_ovr;
  logic [Psize-1:0] shift_next;

  assign chg        = Enable && (PortIn != last_q);
  assign baud_end   = (baud_q == BAUD_LAST);
  assign shift_next = shift_q >> 1;

  // Next-state logic for the frame sequencer, pending slot and overrun flag.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    last_d      = PortIn;
    stash       = 1'b0;
    set_ovr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (chg) begin
          shift_d = PortIn;
          baud_d  = '0;
          state_d = START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        stash = chg;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        stash = chg;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_next;
            txd_d   = shift_next[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (!baud_end) begin
          stash  = chg;
          baud_d = baud_q + 1'b1;
        end else begin
          baud_d = '0;
          if (pend_full_q) begin
            // Drain the slot back-to-back; a change landing now refills it
            // without counting as an overrun since the old value was consumed.
            shift_d     = pend_q;
            state_d     = START;
            txd_d       = 1'b0;
            pend_full_d = chg;
            if (chg) begin
              pend_d = PortIn;
            end
          end else if (chg) begin
            // Slot empty: the change is taken as if seen from IDLE.
            shift_d = PortIn;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (stash) begin
      pend_d      = PortIn;
      pend_full_d = 1'b1;
      set_ovr     = pend_full_q;
    end
  end

  // Set wins over a simultaneous clear so a fresh overrun is never lost.
  assign overrun_d = set_ovr | (overrun_q & ~ClearOverrun);

  // State and output registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      last_q      <= '0;
      overrun_q   <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      last_q      <= last_d;
      overrun_q   <= overrun_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
    end
  end

  assign TxD     = txd_q;
  assign Busy    = busy_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_output_port_serializer.sv
// Bench for output_port_serializer with CLKS_PER_BIT=4. A frame monitor decodes
// TxD and compares each frame against a scoreboard queue of expected bytes.
module tb_output_port_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] PortIn;
  logic       Enable;
  logic       ClearOverrun;
  logic       TxD;
  logic       Busy;
  logic       Overrun;

  output_port_serializer #(.Psize(8), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .PortIn       (PortIn),
    .Enable       (Enable),
    .ClearOverrun (ClearOverrun),
    .TxD          (TxD),
    .Busy         (Busy),
    .Overrun      (Overrun)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0] sb_q[$];

  int busy_cnt, busy_first, busy_last, txd_low;

  typedef struct {
    logic [7:0] value;
    logic       enable;
    logic       exp_frame;
    int         exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Samples Busy/TxD on falling edges for a fixed window.
  task automatic measure(input int window);
    busy_cnt   = 0;
    busy_first = -1;
    busy_last  = -1;
    txd_low    = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (Busy === 1'b1) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = i;
        busy_last = i;
      end
      if (TxD !== 1'b1) txd_low++;
    end
  endtask

  // Frame monitor: each bit must hold for CPB cycles; reset aborts the frame.
  initial begin : monitor
    logic [9:0] bits;
    logic       ok;
    logic       aborted;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (Reset === 1'b0 && TxD === 1'b0) begin
        bits    = '0;
        ok      = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (Reset !== 1'b0) aborted = 1'b1;
            if (c == 0) bits[b] = TxD;
            else if (TxD !== bits[b]) ok = 1'b0;
          end
        end
        if (!aborted) begin
          chk_cnt++;
          if (sb_q.size() == 0) begin
            $display("FAIL frame_expected: got frame %0h with empty scoreboard", bits[8:1]);
          end else begin
            pass_cnt++;
            exp = sb_q.pop_front();
            check("frame_bits", {22'd0, bits}, {22'd0, 1'b1, exp, 1'b0});
            check("frame_bit_hold", {31'd0, ok}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int bad_txd, bad_busy, bad_ovr;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 40};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 40};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 40};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 0};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 0};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 0};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 40};

    // Reset, then 50 quiet cycles with PortIn=0, Enable=1
    Reset = 1'b1; PortIn = 8'h00; Enable = 1'b1; ClearOverrun = 1'b0;
    step(3);
    @(negedge clk);
    check("reset_txd", {31'd0, TxD}, 32'd1);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_overrun", {31'd0, Overrun}, 32'd0);
    @(posedge clk); #1;
    Reset = 1'b0;
    bad_txd = 0; bad_busy = 0; bad_ovr = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1) bad_txd++;
      if (Busy !== 1'b0) bad_busy++;
      if (Overrun !== 1'b0) bad_ovr++;
    end
    check("quiet_txd_bad", bad_txd, 0);
    check("quiet_busy_bad", bad_busy, 0);
    check("quiet_overrun_bad", bad_ovr, 0);

    // Single-frame vectors
    for (int v = 0; v < 7; v++) begin
      step(1);
      Enable = vecs[v].enable;
      PortIn = vecs[v].value;
      if (vecs[v].exp_frame) sb_q.push_back(vecs[v].value);
      measure(60);
      check($sformatf("vec%0d_busy_cycles", v), busy_cnt, vecs[v].exp_busy);
    end
    Enable = 1'b1;
    check("vec_overrun", {31'd0, Overrun}, 32'd0);

    // Update mid-frame: second frame follows with no idle gap
    step(1);
    PortIn = 8'h12; sb_q.push_back(8'h12);
    fork
      measure(120);
      begin step(10); PortIn = 8'h3C; sb_q.push_back(8'h3C); end
    join
    check("chain_busy_cycles", busy_cnt, 80);
    check("chain_busy_span", busy_last - busy_first + 1, 80);
    check("chain_overrun", {31'd0, Overrun}, 32'd0);

    // Change on the final stop cycle with the slot empty
    step(1);
    PortIn = 8'h5A; sb_q.push_back(8'h5A);
    fork
      measure(120);
      begin step(40); PortIn = 8'hA3; sb_q.push_back(8'hA3); end
    join
    check("laststop_busy_span", busy_last - busy_first + 1, 80);
    check("laststop_busy_cycles", busy_cnt, 80);

    // 11 -> 22 -> 33 during one frame: 22 is overwritten
    step(1);
    PortIn = 8'h11; sb_q.push_back(8'h11);
    fork
      measure(120);
      begin
        step(5); PortIn = 8'h22;
        step(5); PortIn = 8'h33; sb_q.push_back(8'h33);
      end
    join
    check("overrun_busy_cycles", busy_cnt, 80);
    check("overrun_set", {31'd0, Overrun}, 32'd1);
    step(1); ClearOverrun = 1'b1;
    step(1); ClearOverrun = 1'b0;
    @(negedge clk);
    check("overrun_cleared", {31'd0, Overrun}, 32'd0);

    // Overrun and clear in the same cycle: set wins
    step(1);
    PortIn = 8'h40; sb_q.push_back(8'h40);
    step(5); PortIn = 8'h44;
    step(5); PortIn = 8'h55; ClearOverrun = 1'b1; sb_q.push_back(8'h55);
    step(1); ClearOverrun = 1'b0;
    @(negedge clk);
    check("set_wins_overrun", {31'd0, Overrun}, 32'd1);
    measure(100);
    step(1); ClearOverrun = 1'b1;
    step(1); ClearOverrun = 1'b0;
    @(negedge clk);
    check("set_wins_cleared", {31'd0, Overrun}, 32'd0);

    // Changes with Enable=0 are absorbed
    step(1);
    Enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      PortIn = (i % 2 == 0) ? 8'hAA : 8'h55;
      step(1);
    end
    PortIn = 8'hAA;
    step(1);
    Enable = 1'b1;
    measure(60);
    check("disabled_busy_cycles", busy_cnt, 0);
    check("disabled_txd_low", txd_low, 0);

    // Reset during data bit 3 with a pending value
    step(1);
    PortIn = 8'h96; sb_q.push_back(8'h96);
    step(8); PortIn = 8'h69;
    step(10);
    Reset = 1'b1; PortIn = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("midreset_txd", {31'd0, TxD}, 32'd1);
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    @(posedge clk); #1;
    Reset = 1'b0;
    sb_q.delete();
    measure(100);
    check("postreset_busy_cycles", busy_cnt, 0);
    check("postreset_txd_low", txd_low, 0);

    step(5);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
